// File: rtl/seq_execute_unit.sv
// Multi-cycle execute unit: single-cycle ALU ops and a shift-add multiplier
// that write back through a registered result port.
module seq_execute_unit #(
  parameter int unsigned DATA_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [3:0]           i_opcode,
  input  logic [DATA_SIZE-1:0] i_operand1,
  input  logic [DATA_SIZE-1:0] i_operand2,
  input  logic [2:0]           i_destination,
  output logic                 o_busy,
  output logic [DATA_SIZE-1:0] o_result,
  output logic [2:0]           o_destination,
  output logic                 o_register_file_write,
  output logic                 o_zero,
  output logic                 o_negative,
  output logic                 o_carry
);
  localparam int unsigned SHW = $clog2(DATA_SIZE);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4,
    OP_SHL = 4'd5, OP_SHR = 4'd6, OP_ASR = 4'd7, OP_MUL = 4'd8, OP_MOV = 4'd9
  } opcode_t;

  state_t               state_q, state_d;
  logic [3:0]           opcode_q, opcode_d;
  logic [DATA_SIZE-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [2:0]           dest_q, dest_d;
  logic [DATA_SIZE-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic                 mul_done_q, mul_done_d;
  logic [DATA_SIZE-1:0] result_q, result_d;
  logic [2:0]           wdest_q, wdest_d;
  logic                 zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;

  logic [DATA_SIZE:0]   add_w, sub_w;
  logic [DATA_SIZE-1:0] alu_res;
  logic                 alu_carry;
  logic [SHW-1:0]       shamt;

  always_comb begin
    shamt     = op2_q[SHW-1:0];
    add_w     = {1'b0, op1_q} + {1'b0, op2_q};
    sub_w     = {1'b0, op1_q} + {1'b0, ~op2_q} + {{DATA_SIZE{1'b0}}, 1'b1};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (opcode_q)
      OP_ADD: begin
        alu_res   = add_w[DATA_SIZE-1:0];
        alu_carry = add_w[DATA_SIZE];
      end
      OP_SUB: begin
        alu_res   = sub_w[DATA_SIZE-1:0];
        alu_carry = sub_w[DATA_SIZE];
      end
      OP_AND:  alu_res = op1_q & op2_q;
      OP_OR:   alu_res = op1_q | op2_q;
      OP_XOR:  alu_res = op1_q ^ op2_q;
      OP_SHL:  alu_res = op1_q << shamt;
      OP_SHR:  alu_res = op1_q >> shamt;
      OP_ASR:  alu_res = $unsigned($signed(op1_q) >>> shamt);
      OP_MOV:  alu_res = op1_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    dest_d     = dest_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mul_done_d = mul_done_q;
    result_d   = result_q;
    wdest_d    = wdest_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    carry_d    = carry_q;

    case (state_q)
      IDLE: begin
        if (i_start && (i_opcode <= OP_MOV)) begin
          opcode_d = i_opcode;
          op1_d    = i_operand1;
          op2_d    = i_operand2;
          dest_d   = i_destination;
          if (i_opcode == OP_MUL) begin
            mcand_d    = i_operand1;
            mplier_d   = i_operand2;
            acc_d      = '0;
            cnt_d      = '0;
            mul_done_d = 1'b0;
            state_d    = MUL;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        result_d = alu_res;
        wdest_d  = dest_q;
        zero_d   = (alu_res == '0);
        neg_d    = alu_res[DATA_SIZE-1];
        carry_d  = alu_carry;
        state_d  = WB;
      end
      MUL: begin
        // DATA_SIZE shift-add iterations, then one extra cycle that commits
        // the accumulator to the result registers (mirrors the EXEC stage).
        if (!mul_done_q) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + SHW'(1);
          if (cnt_q == SHW'(DATA_SIZE - 1)) mul_done_d = 1'b1;
        end else begin
          result_d = acc_q;
          wdest_d  = dest_q;
          zero_d   = (acc_q == '0);
          neg_d    = acc_q[DATA_SIZE-1];
          carry_d  = 1'b0;
          state_d  = WB;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      opcode_q   <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      dest_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      mul_done_q <= 1'b0;
      result_q   <= '0;
      wdest_q    <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      dest_q     <= dest_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mul_done_q <= mul_done_d;
      result_q   <= result_d;
      wdest_q    <= wdest_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      carry_q    <= carry_d;
    end
  end

  assign o_busy                = (state_q != IDLE);
  assign o_register_file_write = (state_q == WB);
  assign o_result              = result_q;
  assign o_destination         = wdest_q;
  assign o_zero                = zero_q;
  assign o_negative            = neg_q;
  assign o_carry               = carry_q;

endmodule

// File: tb/tb_seq_execute_unit.sv
// Scoreboard bench for seq_execute_unit: expected writebacks are queued at
// issue and retired by a monitor whenever the write strobe is seen.
module tb_seq_execute_unit;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    opc = '0;
  logic [DW-1:0] a = '0, b = '0;
  logic [2:0]    dst = '0;
  logic          busy, wr, zf, nf, cf;
  logic [DW-1:0] res;
  logic [2:0]    wdst;

  seq_execute_unit #(.DATA_SIZE(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_opcode(opc),
    .i_operand1(a), .i_operand2(b), .i_destination(dst),
    .o_busy(busy), .o_result(res), .o_destination(wdst),
    .o_register_file_write(wr), .o_zero(zf), .o_negative(nf), .o_carry(cf)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, writes = 0;

  typedef struct {
    logic [DW-1:0] res;
    logic [2:0]    dest;
    logic          z, n, c;
    int            when;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr === 1'b1) begin
      writes++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got res=%h dest=%0d cyc=%0d required no write", res, wdst, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (res !== mon_e.res || wdst !== mon_e.dest || {zf, nf, cf} !== {mon_e.z, mon_e.n, mon_e.c}
            || cyc != mon_e.when) begin
          failures++;
          $display("FAIL writeback got res=%h dest=%0d znc=%b%b%b cyc=%0d required res=%h dest=%0d znc=%b%b%b cyc=%0d",
                   res, wdst, zf, nf, cf, cyc, mon_e.res, mon_e.dest, mon_e.z, mon_e.n, mon_e.c, mon_e.when);
        end
      end
    end
  end

  function automatic exp_t model(input logic [3:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                                 input logic [2:0] d);
    exp_t          e;
    logic [63:0]   wide;
    logic [DW-1:0] ones;
    int unsigned   sh;
    ones   = '1;
    sh     = y[4:0];
    e.c    = 1'b0;
    e.dest = d;
    e.when = 0;
    case (op)
      4'd0: begin wide = 64'(x) + 64'(y); e.res = wide[DW-1:0]; e.c = wide[DW]; end
      4'd1: begin e.res = x - y; e.c = (x >= y); end
      4'd2: e.res = x & y;
      4'd3: e.res = x | y;
      4'd4: e.res = x ^ y;
      4'd5: e.res = x << sh;
      4'd6: e.res = x >> sh;
      4'd7: e.res = (x >> sh) | (x[DW-1] ? ~(ones >> sh) : '0);
      4'd8: begin wide = 64'(x) * 64'(y); e.res = wide[DW-1:0]; end
      4'd9: e.res = x;
      default: e.res = '0;
    endcase
    e.z = (e.res == '0);
    e.n = e.res[DW-1];
    return e;
  endfunction

  // Called at a negedge; the following posedge samples the request.
  task automatic issue_now(input logic [3:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                           input logic [2:0] d);
    exp_t e;
    opc = op; a = x; b = y; dst = d; start = 1'b1;
    if (op <= 4'd9) begin
      e = model(op, x, y, d);
      e.when = cyc + 1 + ((op == 4'd8) ? DW + 1 : 1);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    opc = 4'($urandom); a = $urandom; b = $urandom; dst = 3'($urandom);
  endtask

  task automatic issue(input logic [3:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                       input logic [2:0] d);
    @(negedge clk);
    issue_now(op, x, y, d);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout busy=%b required 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, wr, zf, nf, cf} !== 5'b0 || res !== '0 || wdst !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got busy=%b wr=%b res=%h dest=%0d znc=%b%b%b required all zero",
               busy, wr, res, wdst, zf, nf, cf);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_overflow();
    int w0 = writes;
    issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 3'd3);
    wait_idle("add");
    repeat (3) @(negedge clk);
    checks++;
    if (res !== 32'h8000_0000 || wdst !== 3'd3 || {zf, nf, cf} !== 3'b010 || wr !== 1'b0) begin
      failures++;
      $display("FAIL add_hold got res=%h dest=%0d znc=%b%b%b wr=%b required 80000000 3 010 0",
               res, wdst, zf, nf, cf, wr);
    end
    checks++;
    if (writes - w0 != 1) begin
      failures++;
      $display("FAIL add_pulses got %0d required 1", writes - w0);
    end
  endtask

  task automatic test_carry_zero();
    issue(4'd1, 32'd5, 32'd5, 3'd1);
    wait_idle("sub");
    issue(4'd0, 32'hFFFF_FFFF, 32'd1, 3'd7);
    wait_idle("addwrap");
    issue(4'd1, 32'd3, 32'd5, 3'd2);
    wait_idle("subborrow");
  endtask

  task automatic test_logic_shift();
    issue(4'd7, 32'h8000_0000, 32'h24, 3'd2);
    wait_idle("asr");
    issue(4'd6, 32'h8000_0000, 32'h24, 3'd4);
    wait_idle("shr");
    issue(4'd5, 32'h0000_0001, 32'hFFFF_FFFF, 3'd5);
    wait_idle("shl");
    issue(4'd7, 32'h4000_0000, 32'h1F, 3'd0);
    wait_idle("asr_pos");
    for (int unsigned op = 2; op <= 4; op++) begin
      issue(4'(op), $urandom, $urandom, 3'(op));
      wait_idle("logic");
    end
    issue(4'd9, 32'hDEAD_BEEF, 32'h1234_5678, 3'd0);
    wait_idle("mov");
  endtask

  task automatic test_mul_drop();
    int w0 = writes;
    int n = 0;
    issue(4'd8, 32'h0001_0000, 32'h0001_0001, 3'd6);
    while (busy === 1'b1 && n < 100) begin
      n++;
      start = 1'b1;
      opc = 4'($urandom_range(0, 9));
      a = $urandom; b = $urandom; dst = 3'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (n != DW + 2) begin
      failures++;
      $display("FAIL mul_busy_cycles got %0d required %0d", n, DW + 2);
    end
    checks++;
    if (writes - w0 != 1) begin
      failures++;
      $display("FAIL mul_pulses got %0d required 1", writes - w0);
    end
    issue_now(4'd0, 32'd10, 32'd20, 3'd1);
    wait_idle("after_mul");
    issue(4'd8, $urandom, $urandom, 3'd5);
    wait_idle("mul_rand");
  endtask

  task automatic test_nop();
    int w0 = writes;
    issue(4'd12, 32'd1, 32'd2, 3'd3);
    repeat (3) begin
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL nop_busy got %b required 0", busy);
      end
      @(negedge clk);
    end
    checks++;
    if (writes - w0 != 0) begin
      failures++;
      $display("FAIL nop_pulses got %0d required 0", writes - w0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      issue(4'($urandom_range(0, 9)), $urandom, $urandom, 3'($urandom));
      wait_idle("b2b");
    end
  endtask

  task automatic test_reset_abort();
    int w0 = writes;
    issue(4'd8, 32'h1234_5678, 32'h9ABC_DEF1, 3'd4);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    checks++;
    if (busy !== 1'b0 || wr !== 1'b0 || res !== '0 || wdst !== 3'd0) begin
      failures++;
      $display("FAIL mul_abort got busy=%b wr=%b res=%h dest=%0d required 0 0 0 0", busy, wr, res, wdst);
    end
    @(negedge clk);
    rst = 1'b0;
    issue_now(4'd3, 32'h0F0F_0000, 32'h0000_00F0, 3'd6);
    wait_idle("post_abort");

    issue(4'd0, 32'd5, 32'd6, 3'd2);
    @(posedge clk);
    #1;
    checks++;
    if (wr !== 1'b1) begin
      failures++;
      $display("FAIL wb_strobe got %b required 1", wr);
    end
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    checks++;
    if (busy !== 1'b0 || wr !== 1'b0 || res !== '0) begin
      failures++;
      $display("FAIL wb_abort got busy=%b wr=%b res=%h required 0 0 0", busy, wr, res);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (writes - w0 != 1) begin
      failures++;
      $display("FAIL abort_pulses got %0d required 1", writes - w0);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_carry_zero();
    test_logic_shift();
    test_mul_drop();
    test_nop();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_writes got %0d outstanding required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_execute_unit.md
SEQ_EXECUTE_UNIT -- requirements
Module: seq_execute_unit

Interface
REQ-001 Parameter DATA_SIZE, default 32, operand/result width in bits.
REQ-002 Port i_clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port i_rst  in  1  asynchronous, active-high reset.
REQ-004 Port i_start  in  1  issue request; sampled only in IDLE.
REQ-005 Port i_opcode  in  4  operation select, encoding per REQ-012.
REQ-006 Port i_operand1  in  DATA_SIZE  first operand from the register file asynchronous read port.
REQ-007 Port i_operand2  in  DATA_SIZE  second operand from the register file asynchronous read port.
REQ-008 Port i_destination  in  3  destination register index R0-R7.
REQ-009 Port o_busy  out  1  high while an accepted operation has not yet written back.
REQ-010 Port o_result, o_destination, o_register_file_write  out  DATA_SIZE/3/1  drive the register file write port directly.
REQ-011 Port o_zero, o_negative, o_carry  out  1 each  flags of the last written-back result.

Function
REQ-012 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 ASR, 8 MUL (low DATA_SIZE bits, unsigned shift-add), 9 MOV (operand1); 10-15 are NOP.
REQ-013 FSM states SHALL be IDLE, EXEC, MUL, WB.
REQ-014 In IDLE with i_start=1, the unit SHALL capture i_opcode, both operands and i_destination in that cycle; subsequent changes to these inputs SHALL NOT affect the operation.
REQ-015 Transitions: IDLE->EXEC on start with opcode 0-7, 9; IDLE->MUL on opcode 8; IDLE stays IDLE on NOP (no writeback, no busy); EXEC->WB; MUL->WB after exactly DATA_SIZE iterations; WB->IDLE.
REQ-016 Latency: start at edge N; single-cycle ops SHALL assert o_register_file_write for the cycle after edge N+2; MUL SHALL assert it for the cycle after edge N+DATA_SIZE+2.
REQ-017 o_register_file_write SHALL be high only in WB and for exactly one cycle per accepted non-NOP operation.
REQ-018 o_busy SHALL be high in EXEC, MUL and WB, low in IDLE.
REQ-019 i_start while o_busy=1 SHALL be ignored (dropped, not queued).
REQ-020 Shift ops SHALL use operand2[4:0] (log2(DATA_SIZE) bits) as amount; upper bits ignored.
REQ-021 ADD/SUB SHALL compute in DATA_SIZE+1 bits; o_carry = bit DATA_SIZE (SUB: borrow-free carry of op1 + ~op2 + 1); o_carry=0 for all other ops.
REQ-022 MUL SHALL hold multiplicand, multiplier and accumulator registers plus an iteration counter counting 0..DATA_SIZE-1; overflow bits beyond DATA_SIZE are discarded.
REQ-023 o_zero = (result==0), o_negative = result[DATA_SIZE-1]; flags SHALL update only on the WB edge and hold otherwise.
REQ-024 o_result and o_destination SHALL hold the last written-back values outside WB.
REQ-025 Writes to R0 SHALL be performed like any other register (no hardwired zero).

Reset
REQ-026 i_rst=1 SHALL immediately force IDLE, o_busy=0, o_register_file_write=0, o_result=0, o_destination=0, all flags 0, MUL counter/accumulator 0.
REQ-027 Reset asserted mid-MUL or in WB SHALL abort the operation with no write pulse; after release the unit SHALL accept a new i_start on the first rising edge.

Verification
REQ-028 ADD 0x7FFFFFFF + 0x00000001, dest 3 -> one write pulse, o_result=0x80000000, o_destination=3, negative=1, carry=0, zero=0, pulse 2 cycles after issue.
REQ-029 SUB 5 - 5 -> result 0, zero=1, carry=1; ADD 0xFFFFFFFF + 1 -> result 0, zero=1, carry=1.
REQ-030 MUL 0x00010000 * 0x00010001 -> o_result=0x00010000 after DATA_SIZE+2 cycles, o_busy high throughout, exactly one write pulse.
REQ-031 ASR 0x80000000 by 0x24 (amount 4) -> 0xF8000000; SHR same -> 0x08000000.
REQ-032 i_start pulsed every cycle during a MUL -> all ignored; after WB next start accepted; opcode 12 -> no pulse, busy stays 0.
REQ-033 i_rst raised at MUL iteration 10 -> busy=0 and no write pulse in the same cycle; operands changed after issue -> result unaffected.
